// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter that serialises N requesters' writes into one shared W-bit register.
// Optional owner lock with a bounded burst length is compiled in with `define ARB_LOCK_EN.
module rr_reg_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_LOCK = 8,
  localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  wdata,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [N-1:0]    gnt,
  output logic [W-1:0]    q,
  output logic [IW-1:0]   owner,
  output logic            valid
);

  if (N < 1 || N > 16) begin : g_bad_n
    $error("rr_reg_arbiter: N out of range");
  end
  if (MAX_LOCK < 1 || MAX_LOCK > 255) begin : g_bad_max_lock
    $error("rr_reg_arbiter: MAX_LOCK out of range");
  end

  logic [N-1:0]  gnt_q, gnt_d;
  logic [W-1:0]  q_q, q_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic          win_found;
  logic [IW-1:0] win_idx;

  // Modular add with explicit wrap so indices never reach N, even for non-power-of-2 N.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!win_found && req[wrap_add(ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_q, i);
      end
    end
  end

`ifdef ARB_LOCK_EN
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       lock_hold;

  // The lock is honoured only for the owner that was granted last cycle and is still asking.
  assign lock_hold = gnt_q[owner_q] && req[owner_q] && lock[owner_q] &&
                     ({24'd0, lock_cnt_q} < MAX_LOCK);
`endif

  always_comb begin
    gnt_d   = '0;
    valid_d = 1'b0;
    q_d     = q_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef ARB_LOCK_EN
    lock_cnt_d = '0;
    if (lock_hold) begin
      gnt_d[owner_q] = 1'b1;
      valid_d        = 1'b1;
      q_d            = wdata[int'(owner_q)*W +: W];
      lock_cnt_d     = lock_cnt_q + 8'd1;
    end else
`endif
    if (win_found) begin
      gnt_d[win_idx] = 1'b1;
      valid_d        = 1'b1;
      q_d            = wdata[int'(win_idx)*W +: W];
      owner_d        = win_idx;
      ptr_d          = wrap_add(win_idx, 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign q     = q_q;
  assign owner = owner_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed self-checking bench for rr_reg_arbiter: a N=4 instance and a N=3 instance.
module tb_rr_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        valid;

  logic [2:0]  req3;
  logic [23:0] wdata3;
  logic [2:0]  gnt3;
  logic [7:0]  q3;
  logic [1:0]  owner3;
  logic        valid3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

`ifdef ARB_LOCK_EN
  logic [3:0] lock;
  logic [2:0] lock3;

  rr_reg_arbiter #(.N(4), .W(8), .MAX_LOCK(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .lock(lock),
    .gnt(gnt), .q(q), .owner(owner), .valid(valid)
  );
  rr_reg_arbiter #(.N(3), .W(8), .MAX_LOCK(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .wdata(wdata3), .lock(lock3),
    .gnt(gnt3), .q(q3), .owner(owner3), .valid(valid3)
  );
`else
  rr_reg_arbiter #(.N(4), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .q(q), .owner(owner), .valid(valid)
  );
  rr_reg_arbiter #(.N(3), .W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .wdata(wdata3),
    .gnt(gnt3), .q(q3), .owner(owner3), .valid(valid3)
  );
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] g, input logic [7:0] qq,
                        input logic [1:0] o, input logic v);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".q"}, 32'(q), 32'(qq));
    check({tag, ".owner"}, 32'(owner), 32'(o));
    check({tag, ".valid"}, 32'(valid), 32'(v));
  endtask

  task automatic check3(input string tag, input logic [2:0] g, input logic [7:0] qq,
                        input logic [1:0] o);
    check({tag, ".gnt3"}, 32'(gnt3), 32'(g));
    check({tag, ".q3"}, 32'(q3), 32'(qq));
    check({tag, ".owner3"}, 32'(owner3), 32'(o));
    check({tag, ".valid3"}, 32'(valid3), 32'(g != 3'b000));
  endtask

  initial begin
    logic [3:0] rot_g [5];
    logic [7:0] rot_q [5];
    rot_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

    rst_n  = 1'b0;
    req    = 4'b1111;
    wdata  = {8'h13, 8'h12, 8'h11, 8'h10};
    req3   = 3'b000;
    wdata3 = {8'h22, 8'h21, 8'h20};
`ifdef ARB_LOCK_EN
    lock  = '0;
    lock3 = '0;
`endif

    // Reset held with all requesting
    for (int i = 0; i < 3; i++) begin
      step();
      check4("reset", 4'b0000, 8'h00, 2'd0, 1'b0);
    end

    // Single write from requester 2
    rst_n = 1'b1;
    req   = 4'b0100;
    wdata = {8'h13, 8'hA5, 8'h11, 8'h10};
    step();
    check4("single", 4'b0100, 8'hA5, 2'd2, 1'b1);
    req = 4'b0000;
    step();
    check4("single_idle", 4'b0000, 8'hA5, 2'd2, 1'b0);

    // Rotation from a fresh reset
    rst_n = 1'b0;
    step();
    check4("rst2", 4'b0000, 8'h00, 2'd0, 1'b0);
    rst_n = 1'b1;
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    req   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check4($sformatf("rot%0d", i), rot_g[i], rot_q[i], 2'(i % 4), 1'b1);
    end
    step();
    check4("rot5", 4'b0010, 8'h11, 2'd1, 1'b1);
    step();
    check4("rot6", 4'b0100, 8'h12, 2'd2, 1'b1);

    // Reset while owner=2 drops the flight and restarts from requester 0
    rst_n = 1'b0;
    step();
    check4("midrst", 4'b0000, 8'h00, 2'd0, 1'b0);
    rst_n = 1'b1;
    step();
    check4("post_rst0", 4'b0001, 8'h10, 2'd0, 1'b1);
    step();
    check4("post_rst1", 4'b0010, 8'h11, 2'd1, 1'b1);

    // ptr=2, sparse pattern: 3 wins, then wrap to 0
    req = 4'b1001;
    step();
    check4("sparse0", 4'b1000, 8'h13, 2'd3, 1'b1);
    step();
    check4("sparse1", 4'b0001, 8'h10, 2'd0, 1'b1);
    req = 4'b0000;
    step();
    check4("hold", 4'b0000, 8'h10, 2'd0, 1'b0);

    // N=3 wrap behaviour
    rst_n = 1'b0;
    step();
    check3("n3_rst", 3'b000, 8'h00, 2'd0);
    rst_n = 1'b1;
    req3  = 3'b111;
    step();
    check3("n3_a", 3'b001, 8'h20, 2'd0);
    step();
    check3("n3_b", 3'b010, 8'h21, 2'd1);
    step();
    check3("n3_c", 3'b100, 8'h22, 2'd2);
    step();
    check3("n3_wrap", 3'b001, 8'h20, 2'd0);
    req3 = 3'b101;
    step();
    check3("n3_d", 3'b100, 8'h22, 2'd2);
    step();
    check3("n3_e", 3'b001, 8'h20, 2'd0);
    req3 = 3'b000;

`ifdef ARB_LOCK_EN
    // Lock burst: initial grant + MAX_LOCK locked grants, one yield, then back
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    rst_n = 1'b1;
    req   = 4'b0011;
    lock  = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      check4($sformatf("lock%0d", i), 4'b0001, 8'h10, 2'd0, 1'b1);
    end
    step();
    check4("lock_yield", 4'b0010, 8'h11, 2'd1, 1'b1);
    step();
    check4("lock_back", 4'b0001, 8'h10, 2'd0, 1'b1);
    lock = 4'b0000;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
